mac_req_arbiter: RTL
====================

Name: mac_req_arbiter

Overview:
Shares one four-operand MAC_AXI datapath (A, B, C, D slave channels, one master result channel) between NREQ requesters. Each requester presents a packed {D,C,B,A} operand bundle on a valid/ready handshake. The arbiter grants requesters round-robin and drives the four MAC slave channels with per-channel handshake tracking. It tags each operation and routes every MAC result back to the requester that issued it, in issue order.

Parameters:
DW, 8, operand and result width (matches MAC_AXI DW)
NREQ, 4, number of requesters (2..8)
DEPTH, 4, max operations in flight inside the MAC (tag FIFO depth, power of 2)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
req_valid  in  NREQ  per-requester bundle valid
req_ready  out  NREQ  per-requester bundle accept
req_data  in  NREQ*4*DW  requester i at [i*4*DW +: 4*DW]; within bundle A=[DW-1:0], B next, C next, D top
mac_A/mac_B/mac_C/mac_D  out  DW each  operands to MAC
mac_a_valid/mac_b_valid/mac_c_valid/mac_d_valid  out  1 each  operand valids
mac_a_ready/mac_b_ready/mac_c_ready/mac_d_ready  in  1 each  operand readies
mac_m_data  in  DW  MAC result
mac_m_valid  in  1  result valid
mac_m_ready  out  1  result accept
rsp_data  out  DW  result broadcast to all requesters
rsp_valid  out  NREQ  one-hot result valid (bit = tag of head FIFO entry)
rsp_ready  in  NREQ  per-requester result accept
busy  out  1  high while in ISSUE or tag FIFO non-empty
err_orphan  out  1  sticky: mac_m_valid seen with tag FIFO empty

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; mac_*_valid=0; req_ready=0; tag FIFO empty; mac_m_ready=0; rsp_valid=0; err_orphan=0; busy=0; RR pointer=NREQ-1, so requester 0 has first priority. Reset mid-operation abandons the bundle being issued and all in-flight tags. Results arriving after reset are orphans.
- FSM states: IDLE, ISSUE.
- IDLE:
  - When any req_valid is high and the FIFO count < DEPTH, grant = first requester with valid, scanning from (ptr+1) mod NREQ upward.
  - req_ready[grant]=1 combinationally in that cycle; all other bits are 0.
  - At the edge: capture the bundle into the operand registers, push grant into the tag FIFO, set ptr=grant, clear done_mask[3:0], go to ISSUE.
  - When the FIFO is full, req_ready stays 0 and the state stays IDLE.
- ISSUE:
  - mac_x_valid = ~done_mask[x]; operands are held stable.
  - Channel x is accepted when mac_x_valid & mac_x_ready; set done_mask[x].
  - When (done_mask | accepts_this_cycle) == 4'hF, return to IDLE at that edge.
  - Channels may be accepted in any order and in different cycles. A valid is never dropped before its ready.
- Minimum issue throughput is one bundle per 2 cycles. Capture-to-first-valid latency is 1 cycle.
- Response path:
  - mac_m_ready = FIFO non-empty & rsp_ready[head_tag].
  - rsp_valid = one-hot(head_tag) & {NREQ{mac_m_valid & non-empty}}.
  - rsp_data = mac_m_data, combinational passthrough.
  - On mac_m_valid & mac_m_ready, pop the FIFO.
- Orphan: mac_m_valid with the FIFO empty sets err_orphan; mac_m_ready stays 0. Only reset clears err_orphan.
- Simultaneous push and pop is allowed; count is unchanged. Pop while full frees the slot for the next cycle's capture; full is evaluated on the registered count.
- FIFO pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.

Optional Feature:
MAC_ARB_STRICT_PRIO_EN
- Defined: fixed priority, lowest index with req_valid wins; ptr is unused.
- Undefined: round-robin as above.
- All ports are identical in both builds.

Decomposition:
- Package mac_arb_pkg:
  - state enum {IDLE, ISSUE}
  - TAGW = clog2(NREQ) function/constant
  - channel index constants CH_A..CH_D
- Sub-module mac_arb_tag_fifo (DEPTH x TAGW synchronous FIFO with push/pop/full/empty/count/head). Instantiated once.

Test Plan:
- Single req: req 2 sends A=2,B=3,C=1,D=2 -> req_ready[2] pulses 1 cycle; all four mac valids high the next cycle with those operands; a MAC result of 8 returns with rsp_valid=4'b0100, rsp_data=8.
- All four requesters valid continuously, MAC always ready -> grant order 0,1,2,3,0,...; captures every 2 cycles; results routed in the same order.
- Staggered readies (mac_a_ready in cycle 1, c in cycle 2, b and d in cycle 4) -> each valid drops the cycle after its accept, operands stay stable, return to IDLE after cycle 4, exactly one operation is issued.
- MAC result stalled, DEPTH=4 -> after 4 captures req_ready stays 0. One result handshake frees a slot and the 5th capture occurs the cycle after the pop.
- rsp_ready[head]=0 while mac_m_valid=1 -> mac_m_ready=0 and the result is held. When rsp_ready rises, pop occurs and rsp_valid moves to the next tag.
- Reset held low 1 cycle during ISSUE with 2 tags in flight -> all valids 0 and busy 0; a subsequent mac_m_valid sets err_orphan=1. Build with MAC_ARB_STRICT_PRIO_EN: reqs 1 and 3 always valid -> only req 1 is granted.

Source files
------------

// File: rtl/mac_arb_pkg.sv
// Shared state encoding, channel indices and tag sizing for the MAC request arbiter.
package mac_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam int CH_A = 0;
    localparam int CH_B = 1;
    localparam int CH_C = 2;
    localparam int CH_D = 3;

    function automatic int tag_width(input int nreq);
        return (nreq > 2) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/mac_arb_tag_fifo.sv
// Synchronous tag FIFO remembering which requester owns each in-flight MAC operation.
// Full/empty come from the registered count, so a pop while full frees a slot next cycle.
module mac_arb_tag_fifo
    import mac_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 2,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
        end
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mac_req_arbiter.sv
// Shares one four-operand MAC between NREQ requesters and routes results back in issue order.
// Build macro MAC_ARB_STRICT_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module mac_req_arbiter
    import mac_arb_pkg::*;
#(
    parameter int DW    = 8,
    parameter int NREQ  = 4,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*4*DW-1:0] req_data,
    output logic [DW-1:0]        mac_A,
    output logic [DW-1:0]        mac_B,
    output logic [DW-1:0]        mac_C,
    output logic [DW-1:0]        mac_D,
    output logic                 mac_a_valid,
    output logic                 mac_b_valid,
    output logic                 mac_c_valid,
    output logic                 mac_d_valid,
    input  logic                 mac_a_ready,
    input  logic                 mac_b_ready,
    input  logic                 mac_c_ready,
    input  logic                 mac_d_ready,
    input  logic [DW-1:0]        mac_m_data,
    input  logic                 mac_m_valid,
    output logic                 mac_m_ready,
    output logic [DW-1:0]        rsp_data,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic                 busy,
    output logic                 err_orphan
);

    localparam int TAGW = tag_width(NREQ);
    localparam int BW   = 4 * DW;
    localparam int CW   = $clog2(DEPTH) + 1;

    state_t          state_q, state_d;
    logic [3:0]      done_q, done_d;
    logic [BW-1:0]   ops_q, ops_d;
    logic            err_q, err_d;
    logic [TAGW-1:0] grant_idx;
    logic            grant_vld;
    logic [3:0]      ch_vld, ch_rdy, ch_acc;
    logic            push;
    logic            fifo_pop;
    logic [TAGW-1:0] head_tag;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
`ifndef MAC_ARB_STRICT_PRIO_EN
    logic [TAGW-1:0] ptr_q, ptr_d;
    int              scan_idx;
`endif

    assign ch_rdy[CH_A] = mac_a_ready;
    assign ch_rdy[CH_B] = mac_b_ready;
    assign ch_rdy[CH_C] = mac_c_ready;
    assign ch_rdy[CH_D] = mac_d_ready;

    assign mac_a_valid = ch_vld[CH_A];
    assign mac_b_valid = ch_vld[CH_B];
    assign mac_c_valid = ch_vld[CH_C];
    assign mac_d_valid = ch_vld[CH_D];

    assign mac_A = ops_q[CH_A*DW +: DW];
    assign mac_B = ops_q[CH_B*DW +: DW];
    assign mac_C = ops_q[CH_C*DW +: DW];
    assign mac_D = ops_q[CH_D*DW +: DW];

    assign busy       = (state_q == ISSUE) | (fifo_count != '0);
    assign err_orphan = err_q;
    assign rsp_data   = mac_m_data;

    // Winner selection; scanning from the far end lets the closest candidate overwrite.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
`ifdef MAC_ARB_STRICT_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_vld = 1'b1;
                grant_idx = TAGW'(i);
            end
        end
`else
        scan_idx = 0;
        for (int k = NREQ; k >= 1; k--) begin
            scan_idx = (int'(ptr_q) + k) % NREQ;
            if (req_valid[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = TAGW'(scan_idx);
            end
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        ops_d     = ops_q;
        req_ready = '0;
        push      = 1'b0;
        ch_vld    = '0;
        ch_acc    = '0;
`ifndef MAC_ARB_STRICT_PRIO_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_vld && !fifo_full) begin
                    req_ready[grant_idx] = 1'b1;
                    push                 = 1'b1;
                    ops_d                = req_data[int'(grant_idx)*BW +: BW];
                    done_d               = '0;
                    state_d              = ISSUE;
`ifndef MAC_ARB_STRICT_PRIO_EN
                    ptr_d                = grant_idx;
`endif
                end
            end
            ISSUE: begin
                ch_vld = ~done_q;
                ch_acc = ch_vld & ch_rdy;
                done_d = done_q | ch_acc;
                if (done_d == 4'hF) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result routing: the FIFO head names the owner of the result now on the bus.
    always_comb begin
        mac_m_ready         = ~fifo_empty & rsp_ready[head_tag];
        fifo_pop            = mac_m_valid & mac_m_ready;
        rsp_valid           = '0;
        rsp_valid[head_tag] = mac_m_valid & ~fifo_empty;
        err_d               = err_q | (mac_m_valid & fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            done_q  <= '0;
            err_q   <= 1'b0;
`ifndef MAC_ARB_STRICT_PRIO_EN
            ptr_q   <= TAGW'(NREQ - 1);
`endif
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifndef MAC_ARB_STRICT_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        ops_q <= ops_d;
    end

    mac_arb_tag_fifo #(
        .DEPTH (DEPTH),
        .W     (TAGW)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (grant_idx),
        .pop       (fifo_pop),
        .head      (head_tag),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
